// File: rtl/fp_result_fifo.sv
// fp_result_fifo: classifies FP32 products from the fp multiplier and buffers
// them (product + class) in a small FIFO with valid/ready on both sides.
// Optional build macro FP_RESULT_STATS_EN adds saturating counters of pushed
// zero / inf / NaN products with a synchronous clear (stat_clr).
module fp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   in_p,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [31:0]   out_p,
  output logic [2:0]    out_class,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
`ifdef FP_RESULT_STATS_EN
  ,
  input  logic          stat_clr,
  output logic [15:0]   stat_zero,
  output logic [15:0]   stat_inf,
  output logic [15:0]   stat_nan
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] CLS_ZERO   = 3'd0;
  localparam logic [2:0] CLS_SUB    = 3'd1;
  localparam logic [2:0] CLS_NORMAL = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_NAN    = 3'd4;

  logic [31:0]   mem_p [DEPTH];
  logic [2:0]    mem_c [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    in_class;
  logic          push;
  logic          pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Output a clean zero while empty so stale storage never leaks downstream.
  assign out_p     = empty ? 32'd0 : mem_p[rd_ptr];
  assign out_class = empty ? CLS_ZERO : mem_c[rd_ptr];

  // Classify the incoming product from its exponent and mantissa; sign ignored.
  always_comb begin
    in_class = CLS_NORMAL;
    if (in_p[30:23] == 8'h00) begin
      in_class = (in_p[22:0] == 23'd0) ? CLS_ZERO : CLS_SUB;
    end else if (in_p[30:23] == 8'hFF) begin
      in_class = (in_p[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end
  end

  // Storage array has no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_p[wr_ptr] <= in_p;
      mem_c[wr_ptr] <= in_class;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks push-only / pop-only cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef FP_RESULT_STATS_EN
  // Saturating class counters; a clear in the same cycle as a push wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_zero <= 16'd0;
      stat_inf  <= 16'd0;
      stat_nan  <= 16'd0;
    end else if (stat_clr) begin
      stat_zero <= 16'd0;
      stat_inf  <= 16'd0;
      stat_nan  <= 16'd0;
    end else if (push) begin
      if (in_class == CLS_ZERO && stat_zero != 16'hFFFF) begin
        stat_zero <= stat_zero + 16'd1;
      end
      if (in_class == CLS_INF && stat_inf != 16'hFFFF) begin
        stat_inf <= stat_inf + 16'd1;
      end
      if (in_class == CLS_NAN && stat_nan != 16'hFFFF) begin
        stat_nan <= stat_nan + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_result_fifo.sv
// tb_fp_result_fifo: randomized scoreboard bench for fp_result_fifo (DEPTH=4).
// Accepted pushes enqueue the expected product/class; a negedge monitor
// compares the DUT head and status flags against the reference queue.
module tb_fp_result_fifo;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic [31:0]   in_p;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   out_p;
   logic [2:0]    out_class;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
`ifdef FP_RESULT_STATS_EN
   logic          stat_clr;
   logic [15:0]   stat_zero;
   logic [15:0]   stat_inf;
   logic [15:0]   stat_nan;
   int            ref_zero;
   int            ref_inf;
   int            ref_nan;
`endif

   int            checks;
   int            errors;
   logic [31:0]   exp_p [$];
   int            exp_c [$];

   fp_result_fifo #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_p      (in_p),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_p     (out_p),
      .out_class (out_class),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .empty     (empty)
`ifdef FP_RESULT_STATS_EN
      ,
      .stat_clr  (stat_clr),
      .stat_zero (stat_zero),
      .stat_inf  (stat_inf),
      .stat_nan  (stat_nan)
`endif
   );

   // Free-running 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference classification straight from the IEEE-754 field rules
   function automatic int refClass(input logic [31:0] p);
      int e;
      int m;
      e = int'((p >> 23) % 256);
      m = int'(p % 32'h0080_0000);
      if (e == 0)   return (m == 0) ? 0 : 1;
      if (e == 255) return (m == 0) ? 3 : 4;
      return 2;
   endfunction

   // Single comparison point: counts every check and reports each failure
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs; an accepted push enqueues its expected result
   task automatic applyStimulus(input logic v, input logic [31:0] p, input logic ordy);
      logic acc;
      int   cls;
      in_valid  = v;
      in_p      = p;
      out_ready = ordy;
      @(negedge clk);
      acc = in_valid && in_ready;
      cls = refClass(in_p);
      @(posedge clk);
      if (acc) begin
         exp_p.push_back(p);
         exp_c.push_back(cls);
      end
`ifdef FP_RESULT_STATS_EN
      if (stat_clr) begin
         ref_zero = 0;
         ref_inf  = 0;
         ref_nan  = 0;
      end else if (acc) begin
         if (cls == 0 && ref_zero < 65535) ref_zero++;
         if (cls == 3 && ref_inf  < 65535) ref_inf++;
         if (cls == 4 && ref_nan  < 65535) ref_nan++;
      end
`endif
      #1;
   endtask

   // Monitor: compare DUT head and flags with the reference queue every cycle
   always @(negedge clk) begin
      int sz;
      if (rst_n) begin
         sz = exp_p.size();
         checkOutput("count", 32'(count), 32'(sz));
         checkOutput("empty", 32'(empty), 32'(sz == 0));
         checkOutput("full", 32'(full), 32'(sz == DEPTH));
         checkOutput("in_ready", 32'(in_ready), 32'(sz < DEPTH));
         checkOutput("out_valid", 32'(out_valid), 32'(sz > 0));
         if (sz > 0) begin
            checkOutput("out_p", out_p, exp_p[0]);
            checkOutput("out_class", 32'(out_class), 32'(exp_c[0]));
            if (out_valid && out_ready) begin
               void'(exp_p.pop_front());
               void'(exp_c.pop_front());
            end
         end else begin
            checkOutput("out_p_empty", out_p, 32'd0);
            checkOutput("out_class_empty", 32'(out_class), 32'd0);
         end
`ifdef FP_RESULT_STATS_EN
         checkOutput("stat_zero", 32'(stat_zero), 32'(ref_zero));
         checkOutput("stat_inf", 32'(stat_inf), 32'(ref_inf));
         checkOutput("stat_nan", 32'(stat_nan), 32'(ref_nan));
`endif
      end
   end

   function automatic logic [31:0] randOperand();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 5))
         0: r[30:0] = 31'd0;
         1: r[30:23] = 8'h00;
         2: r[30:23] = 8'hFF;
         3: r[30:0] = 31'h7F80_0000;
         default: ;
      endcase
      return r;
   endfunction

   // Main stimulus sequence
   initial begin
      logic [31:0] cls_in  [5];
      int          cls_exp [5];
      logic [31:0] pend;
      logic        pend_v;
      int          pushes;

      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_p      = 32'd0;
      out_ready = 1'b0;
`ifdef FP_RESULT_STATS_EN
      stat_clr  = 1'b0;
      ref_zero  = 0;
      ref_inf   = 0;
      ref_nan   = 0;
`endif

      // Reset held for two cycles, then released
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_out_p", out_p, 32'd0);

      // Classification with one-cycle latency
      $display("[TB] classification");
      cls_in  = '{32'h4B80_0000, 32'h8000_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000};
      cls_exp = '{2, 0, 1, 3, 4};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, cls_in[i], 1'b1);
         checkOutput("cls_valid", 32'(out_valid), 32'd1);
         checkOutput("cls_p", out_p, cls_in[i]);
         checkOutput("cls_class", 32'(out_class), 32'(cls_exp[i]));
      end
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("cls_drained", 32'(empty), 32'd1);

      // Fill to full with the consumer stalled, then drain
      $display("[TB] fill/full");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h4100_0000 + 32'(i), 1'b0);
      end
      checkOutput("fill_full", 32'(full), 32'd1);
      checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
      checkOutput("fill_count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("drain_p", out_p, 32'h4100_0000 + 32'(i));
         applyStimulus(1'b0, 32'd0, 1'b1);
      end
      checkOutput("drain_empty", 32'(empty), 32'd1);

      // Simultaneous push/pop at count 2 and while full
      $display("[TB] simultaneous push/pop");
      applyStimulus(1'b1, 32'h3F80_0000, 1'b0);
      applyStimulus(1'b1, 32'h4000_0000, 1'b0);
      applyStimulus(1'b1, 32'h4040_0000, 1'b1);
      checkOutput("pp_count2", 32'(count), 32'd2);
      applyStimulus(1'b1, 32'h4080_0000, 1'b0);
      applyStimulus(1'b1, 32'h40A0_0000, 1'b0);
      applyStimulus(1'b1, 32'h40C0_0000, 1'b1);
      checkOutput("pp_full_count3", 32'(count), 32'd3);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b1);

      // Randomized wrap-around with stalls; pending data held until accepted
      $display("[TB] random wrap-around");
      pushes = 0;
      pend_v = 1'b0;
      pend   = 32'd0;
      for (int i = 0; i < 200 && pushes < 40; i++) begin
         if (!pend_v && $urandom_range(0, 3) != 0) begin
            pend_v = 1'b1;
            pend   = randOperand();
         end
         if (pend_v) begin
            applyStimulus(1'b1, pend, 1'($urandom_range(0, 1)));
            if (exp_p.size() > 0 && exp_p[exp_p.size()-1] === pend) begin
               pend_v = 1'b0;
               pushes++;
            end
         end else begin
            applyStimulus(1'b0, $urandom, 1'($urandom_range(0, 1)));
         end
      end
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b1);

`ifdef FP_RESULT_STATS_EN
      // Class counters, clear priority over a coinciding push
      $display("[TB] stats");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0000_0000, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'hFF80_0000, 1'b1);
      applyStimulus(1'b1, 32'h7FC0_0001, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("stat_zero_3", 32'(stat_zero), 32'd3);
      checkOutput("stat_inf_2", 32'(stat_inf), 32'd2);
      checkOutput("stat_nan_1", 32'(stat_nan), 32'd1);
      stat_clr = 1'b1;
      applyStimulus(1'b1, 32'h0000_0000, 1'b1);
      stat_clr = 1'b0;
      checkOutput("stat_clr_zero", 32'(stat_zero), 32'd0);
      checkOutput("stat_clr_inf", 32'(stat_inf), 32'd0);
      checkOutput("stat_clr_nan", 32'(stat_nan), 32'd0);
      applyStimulus(1'b1, 32'h7F80_0000, 1'b0);
      applyStimulus(1'b1, 32'h0000_0000, 1'b0);
`endif

      // Asynchronous reset in the middle of a burst
      $display("[TB] async reset mid-burst");
      applyStimulus(1'b1, 32'h4120_0000, 1'b0);
      applyStimulus(1'b1, 32'h4130_0000, 1'b0);
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_count", 32'(count), 32'd0);
      checkOutput("mid_rst_empty", 32'(empty), 32'd1);
      checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_out_p", out_p, 32'd0);
`ifdef FP_RESULT_STATS_EN
      checkOutput("mid_rst_stat_zero", 32'(stat_zero), 32'd0);
      checkOutput("mid_rst_stat_inf", 32'(stat_inf), 32'd0);
      ref_zero = 0;
      ref_inf  = 0;
      ref_nan  = 0;
`endif
      exp_p.delete();
      exp_c.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(1'b1, 32'hC2F6_E979, 1'b0);
      checkOutput("post_rst_p", out_p, 32'hC2F6_E979);
      applyStimulus(1'b0, 32'd0, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
